// File: rtl/vjtag_dr_bridge.sv
// Virtual-JTAG data-register bridge: shifts WIDTH-bit words between a virtual JTAG
// node and clk-domain valid/ready streams, with every JTAG input synchronized into clk.
module vjtag_dr_bridge #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tck,
  input  logic             tdi,
  input  logic             ir_in,
  input  logic             virtual_state_cdr,
  input  logic             virtual_state_sdr,
  input  logic             virtual_state_udr,
  output logic             tdo,
  output logic [WIDTH-1:0] wr_data,
  output logic             wr_valid,
  input  logic             wr_ready,
  input  logic [WIDTH-1:0] rd_data,
  input  logic             rd_valid,
  output logic             rd_ready,
  output logic             overflow,
  output logic             short_frame
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

  // bit order in the synchronizer bundle: {tck, tdi, ir_in, cdr, sdr, udr}
  logic [5:0]       r_sync1;
  logic [5:0]       r_sync2;
  logic             r_tck_prev;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_tdo;
  logic [WIDTH-1:0] r_wr_data;
  logic             r_wr_valid;
  logic [WIDTH-1:0] r_rd_buf;
  logic             r_rd_full;
  logic             r_overflow;
  logic             r_short_frame;

  logic             w_tdi;
  logic             w_ir;
  logic             w_cdr;
  logic             w_sdr;
  logic             w_udr;
  logic             w_tck_rise;
  logic             w_ev_cdr;
  logic             w_ev_sdr;
  logic             w_ev_udr;
  logic             w_frame_done;
  logic             w_short;
  logic             w_wr_load;
  logic             w_wr_drop;
  logic             w_rd_take;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [CW-1:0]    w_cnt_nxt;

  assign w_tdi      = r_sync2[4];
  assign w_ir       = r_sync2[3];
  assign w_cdr      = r_sync2[2];
  assign w_sdr      = r_sync2[1];
  assign w_udr      = r_sync2[0];
  assign w_tck_rise = r_sync2[5] & ~r_tck_prev;

  // At most one state event per tck edge, CDR winning over SDR over UDR.
  assign w_ev_cdr = w_tck_rise & w_cdr;
  assign w_ev_sdr = w_tck_rise & ~w_cdr & w_sdr;
  assign w_ev_udr = w_tck_rise & ~w_cdr & ~w_sdr & w_udr;

  assign w_frame_done = w_ev_udr & ~w_ir & (r_bit_cnt == FULL_CNT);
  assign w_short      = w_ev_udr & ~w_ir & (r_bit_cnt != FULL_CNT);
  assign w_wr_load    = w_frame_done & (~r_wr_valid | wr_ready);
  assign w_wr_drop    = w_frame_done & r_wr_valid & ~wr_ready;
  assign w_rd_take    = w_ev_cdr & w_ir & r_rd_full;

  // Next shift-register contents and saturating shift count
  always_comb begin
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_bit_cnt;
    if (w_ev_cdr) begin
      w_cnt_nxt = '0;
      if (w_rd_take) begin
        w_shreg_nxt = r_rd_buf;
      end else begin
        w_shreg_nxt = '0;
      end
    end else if (w_ev_sdr) begin
      w_shreg_nxt = {w_tdi, r_shreg[WIDTH-1:1]};
      if (r_bit_cnt != FULL_CNT) begin
        w_cnt_nxt = r_bit_cnt + CW'(1);
      end else begin
        w_cnt_nxt = r_bit_cnt;
      end
    end else begin
      w_shreg_nxt = r_shreg;
      w_cnt_nxt   = r_bit_cnt;
    end
  end

  // Two-flop synchronizers and tck edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 6'b000000;
      r_sync2    <= 6'b000000;
      r_tck_prev <= 1'b0;
    end else begin
      r_sync1    <= {tck, tdi, ir_in, virtual_state_cdr, virtual_state_sdr, virtual_state_udr};
      r_sync2    <= r_sync1;
      r_tck_prev <= r_sync2[5];
    end
  end

  // Shift register, bit counter and tdo, which tracks the new shreg[0] on each load/shift
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_tdo     <= 1'b0;
    end else begin
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_cnt_nxt;
      if (w_ev_cdr || w_ev_sdr) begin
        r_tdo <= w_shreg_nxt[0];
      end
    end
  end

  // Write word handshake and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_data     <= '0;
      r_wr_valid    <= 1'b0;
      r_overflow    <= 1'b0;
      r_short_frame <= 1'b0;
    end else begin
      if (w_wr_load) begin
        r_wr_data  <= r_shreg;
        r_wr_valid <= 1'b1;
      end else if (r_wr_valid && wr_ready) begin
        r_wr_valid <= 1'b0;
      end
      if (w_wr_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_short) begin
        r_short_frame <= 1'b1;
      end
    end
  end

  // Single-entry read buffer; a capture that empties it blocks refill until the next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_buf  <= '0;
      r_rd_full <= 1'b0;
    end else begin
      if (w_rd_take) begin
        r_rd_full <= 1'b0;
      end else if (rd_valid && !r_rd_full) begin
        r_rd_buf  <= rd_data;
        r_rd_full <= 1'b1;
      end
    end
  end

  assign tdo         = r_tdo;
  assign wr_data     = r_wr_data;
  assign wr_valid    = r_wr_valid;
  assign rd_ready    = ~r_rd_full;
  assign overflow    = r_overflow;
  assign short_frame = r_short_frame;

endmodule
